// File: rtl/uart_pkg.sv
// uart_pkg: shared types and elaboration helpers for the UART blocks.
// The transmitter's optional parity stage is controlled by UART_TX_PARITY_EN;
// the PARITY encoding exists here in both builds so the receiver can share it.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Clocks per line bit; integer division, result must be >= 2.
    function automatic int uart_clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    // Bits needed to hold values 0..value-1, never less than 1.
    function automatic int uart_clog2(input int value);
        int width;
        width = 1;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter shared by the UART transmitter and the
// future receiver. Counts 0..CLKS_PER_BIT-1, wraps, and flags the last count.
// A synchronous restart pins the phase to the caller's event (no free-run).
// Build macro of the enclosing transmitter: UART_TX_PARITY_EN (no effect here).
import uart_pkg::*;

module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 434,
    parameter int CNT_W        = uart_clog2(CLKS_PER_BIT)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_restart,
    output logic             o_tick,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;
    logic             w_wrap;

    assign w_wrap  = (r_count == CNT_W'(CLKS_PER_BIT - 1));
    assign o_tick  = w_wrap;
    assign o_count = r_count;

    // Bit-period counter: restart or wrap returns to 0, otherwise increment.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_restart || w_wrap) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with internal baud divider,
// valid/ready input and configurable data width / stop-bit count.
// Optional parity bit between data and stop: define UART_TX_PARITY_EN
// (adds parameter PARITY_ODD).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | line high, ready for a payload; also the last cycle of the
//           | final stop bit, which is where tx_done pulses
// ST_START  | start bit (0) for one bit period
// ST_DATA   | payload bits, LSB first, one bit period each
// ST_PARITY | parity bit (UART_TX_PARITY_EN builds only)
// ST_STOP   | stop bits (1); left one cycle early on the final stop bit
//
// Leaving STOP one cycle early lets IDLE supply the final stop cycle, so a
// payload accepted in the tx_done cycle starts exactly one frame after the
// previous start bit: frames abut with no idle gap.
import uart_pkg::*;

module uart_tx_param #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 115200,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
`ifdef UART_TX_PARITY_EN
    ,
    parameter bit PARITY_ODD = 1'b0
`endif
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [DATA_BITS-1:0] i_tx_data,
    input  logic                 i_tx_valid,
    output logic                 o_tx_ready,
    output logic                 o_tx_busy,
    output logic                 o_tx_done,
    output logic                 o_txd
);

    localparam int CLKS_PER_BIT = uart_clks_per_bit(CLK_FREQ, BAUD);
    localparam int CNT_W        = uart_clog2(CLKS_PER_BIT);
    localparam int IDX_W        = uart_clog2(DATA_BITS);

    uart_state_e          r_state;
    logic                 r_txd;
    logic                 r_busy;
    logic                 r_done;
    logic [IDX_W-1:0]     r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
`ifdef UART_TX_PARITY_EN
    logic                 r_parity;
`endif

    logic             w_restart;
    logic             w_tick;
    logic [CNT_W-1:0] w_baud_cnt;
    logic             w_last_cyc;
    logic             w_last_data;
    logic             w_last_stop;

    // Counter is held at 0 while idle, so it starts at 0 on acceptance.
    assign w_restart   = (r_state == ST_IDLE);
    assign w_last_cyc  = (w_baud_cnt == CNT_W'(CLKS_PER_BIT - 2));
    assign w_last_data = (r_bit_idx == IDX_W'(DATA_BITS - 1));
    assign w_last_stop = (r_bit_idx == IDX_W'(STOP_BITS - 1));

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_restart (w_restart),
        .o_tick    (w_tick),
        .o_count   (w_baud_cnt)
    );

    // Frame sequencer with registered line, busy and done outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_txd     <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bit_idx <= '0;
            r_shift   <= '0;
`ifdef UART_TX_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_txd <= 1'b1;
                    if (i_tx_valid) begin
                        r_shift <= i_tx_data;
`ifdef UART_TX_PARITY_EN
                        r_parity <= (^i_tx_data) ^ PARITY_ODD;
`endif
                        r_txd   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_tick) begin
                        r_txd     <= r_shift[0];
                        r_shift   <= r_shift >> 1;
                        r_bit_idx <= '0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        if (w_last_data) begin
                            r_bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
                            r_txd   <= r_parity;
                            r_state <= ST_PARITY;
`else
                            r_txd   <= 1'b1;
                            r_state <= ST_STOP;
`endif
                        end else begin
                            r_txd     <= r_shift[0];
                            r_shift   <= r_shift >> 1;
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_tick) begin
                        r_txd     <= 1'b1;
                        r_bit_idx <= '0;
                        r_state   <= ST_STOP;
                    end
                end
`endif
                ST_STOP: begin
                    r_txd <= 1'b1;
                    if (w_last_stop && w_last_cyc) begin
                        r_bit_idx <= '0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= ST_IDLE;
                    end else if (w_tick) begin
                        r_bit_idx <= r_bit_idx + IDX_W'(1);
                    end
                end
                default: begin
                    r_txd     <= 1'b1;
                    r_busy    <= 1'b0;
                    r_bit_idx <= '0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_txd      = r_txd;
    assign o_tx_busy  = r_busy;
    assign o_tx_ready = ~r_busy;
    assign o_tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: 10 clocks per bit. Instance 0 is 8N1, instance 1
// is 7 data / 2 stop; with UART_TX_PARITY_EN two 8E1/8O1 instances are added.
module tb_uart_tx_param;

`ifdef UART_TX_PARITY_EN
    localparam int NI = 4;
    localparam int NV = 7;
`else
    localparam int NI = 2;
    localparam int NV = 5;
`endif

    logic       clk;
    logic       rst_n;
    logic       v_valid [NI];
    logic [7:0] d0;
    logic [6:0] d1;
    logic       w_txd   [NI];
    logic       w_ready [NI];
    logic       w_busy  [NI];
    logic       w_done  [NI];
`ifdef UART_TX_PARITY_EN
    logic [7:0] d2;
    logic [7:0] d3;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          sel;
        logic [7:0]  data;
        logic [10:0] exp;      // txd level per bit slot, bit 0 = start bit
        int          nbits;
        bit          hold;     // keep valid high for a back-to-back frame
        int          pulse_at; // cycle to pulse valid while busy, 0 = none
        string       name;
    } vec_t;

    vec_t vecs [NV];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    uart_tx_param #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .STOP_BITS(1)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(d0), .i_tx_valid(v_valid[0]),
        .o_tx_ready(w_ready[0]), .o_tx_busy(w_busy[0]), .o_tx_done(w_done[0]), .o_txd(w_txd[0]));

    uart_tx_param #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(7), .STOP_BITS(2)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(d1), .i_tx_valid(v_valid[1]),
        .o_tx_ready(w_ready[1]), .o_tx_busy(w_busy[1]), .o_tx_done(w_done[1]), .o_txd(w_txd[1]));

`ifdef UART_TX_PARITY_EN
    uart_tx_param #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1'b0)) u_pe (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(d2), .i_tx_valid(v_valid[2]),
        .o_tx_ready(w_ready[2]), .o_tx_busy(w_busy[2]), .o_tx_done(w_done[2]), .o_txd(w_txd[2]));

    uart_tx_param #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1'b1)) u_po (
        .i_clk(clk), .i_rst_n(rst_n), .i_tx_data(d3), .i_tx_valid(v_valid[3]),
        .o_tx_ready(w_ready[3]), .o_tx_busy(w_busy[3]), .o_tx_done(w_done[3]), .o_txd(w_txd[3]));
`endif

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic set_in(input int sel, input logic valid, input logic [7:0] d);
        v_valid[sel] = valid;
        case (sel)
            0: d0 = d;
            1: d1 = d[6:0];
`ifdef UART_TX_PARITY_EN
            2: d2 = d;
            3: d3 = d;
`endif
            default: ;
        endcase
    endtask

    // Called on a negedge with the instance ready; acceptance happens on the
    // next posedge, so the following negedge is cycle 1 of the frame.
    task automatic run_frame(input vec_t v);
        logic [10:0] obs;
        int glitches, done_cnt, done_at, rb_err, last, bi;
        obs = '0; glitches = 0; done_cnt = 0; done_at = 0; rb_err = 0;
        last = v.nbits * 10;
        set_in(v.sel, 1'b1, v.data);
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            bi = (k - 1) / 10;
            if (w_txd[v.sel] !== v.exp[bi]) glitches++;
            if ((k - 1) % 10 == 5) obs[bi] = w_txd[v.sel];
            if (w_done[v.sel] === 1'b1) begin
                done_cnt++;
                done_at = k;
            end
            if (k < last) begin
                if (w_ready[v.sel] !== 1'b0 || w_busy[v.sel] !== 1'b1) rb_err++;
            end else begin
                if (w_ready[v.sel] !== 1'b1 || w_busy[v.sel] !== 1'b0) rb_err++;
            end
            if (k == 1 && !v.hold) v_valid[v.sel] = 1'b0;
            if (v.pulse_at != 0 && k == v.pulse_at) set_in(v.sel, 1'b1, 8'h00);
            if (v.pulse_at != 0 && k == v.pulse_at + 1) v_valid[v.sel] = 1'b0;
        end
        check({v.name, "_bits"},       int'(obs), int'(v.exp));
        check({v.name, "_txd_cycles"}, glitches, 0);
        check({v.name, "_done_cycle"}, done_at, last);
        check({v.name, "_done_count"}, done_cnt, 1);
        check({v.name, "_ready_busy"}, rb_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int extra_done, line_err;
        vec_t rv;

        vecs[0] = '{0, 8'h55, 11'h2AA, 10, 1'b0, 0,  "a_55"};
        vecs[1] = '{0, 8'hA3, 11'h346, 10, 1'b1, 0,  "a_a3_hold"};
        vecs[2] = '{0, 8'h0F, 11'h21E, 10, 1'b0, 40, "a_0f_b2b_pulse"};
        vecs[3] = '{1, 8'h7F, 11'h3FE, 10, 1'b0, 0,  "b_7f_2stop"};
        vecs[4] = '{1, 8'h2A, 11'h354, 10, 1'b0, 55, "b_2a_pulse"};
`ifdef UART_TX_PARITY_EN
        vecs[5] = '{2, 8'h55, 11'h4AA, 11, 1'b0, 0,  "pe_55"};
        vecs[6] = '{3, 8'h01, 11'h402, 11, 1'b0, 0,  "po_01"};
`endif

        rst_n = 1'b0;
        d0 = '0;
        d1 = '0;
`ifdef UART_TX_PARITY_EN
        d2 = '0;
        d3 = '0;
`endif
        for (int i = 0; i < NI; i++) v_valid[i] = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < NI; i++) begin
            check($sformatf("reset_txd_%0d", i),   int'(w_txd[i]),   1);
            check($sformatf("reset_ready_%0d", i), int'(w_ready[i]), 1);
            check($sformatf("reset_busy_%0d", i),  int'(w_busy[i]),  0);
            check($sformatf("reset_done_%0d", i),  int'(w_done[i]),  0);
        end

        for (int i = 0; i < NV; i++) begin
            run_frame(vecs[i]);
        end
        repeat (3) @(negedge clk);

        // Reset in the middle of a frame on instance 0 (bit slot 3 of 0xA3 is 0).
        set_in(0, 1'b1, 8'hA3);
        @(negedge clk);
        v_valid[0] = 1'b0;
        repeat (34) @(negedge clk);
        check("rst_pre_txd",  int'(w_txd[0]),  0);
        check("rst_pre_busy", int'(w_busy[0]), 1);
        rst_n = 1'b0;
        #1;
        check("rst_txd",   int'(w_txd[0]),   1);
        check("rst_busy",  int'(w_busy[0]),  0);
        check("rst_ready", int'(w_ready[0]), 1);
        check("rst_done",  int'(w_done[0]),  0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        extra_done = 0;
        line_err = 0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (w_done[0] !== 1'b0) extra_done++;
            if (w_txd[0] !== 1'b1) line_err++;
        end
        check("rst_after_done", extra_done, 0);
        check("rst_after_line", line_err, 0);

        rv = '{0, 8'h0F, 11'h21E, 10, 1'b0, 0, "a_0f_after_rst"};
        run_frame(rv);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
